// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit serializer: state encoding,
// line levels and default frame geometry.
package uart_tx_serializer_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_START = 2'd1,
    STATE_DATA  = 2'd2,
    STATE_STOP  = 2'd3
  } state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  localparam int DEFAULT_DATA_BITS     = 8;
  localparam int DEFAULT_STOP_BITS     = 1;
  localparam int DEFAULT_BIT_CNT_WIDTH = 3;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: starts the bit-rate divider, shifts start/data/stop
// bits out on each divider tick, then stops the divider and returns to idle.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int STOP_BITS     = DEFAULT_STOP_BITS,
  parameter int BIT_CNT_WIDTH = DEFAULT_BIT_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_data_stb,
  input  logic                 i_div_clk_rose,
  output logic                 o_div_start_stb,
  output logic                 o_div_reset_stb,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done_stb
);

  localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST  = BIT_CNT_WIDTH'(DATA_BITS - 1);
  localparam logic                     STOP_LAST = (STOP_BITS == 2);

  state_t                   state_reg, state_next;
  logic [DATA_BITS-1:0]     shift_reg, shift_next;
  logic [BIT_CNT_WIDTH-1:0] bit_idx_reg, bit_idx_next;
  logic                     stop_cnt_reg, stop_cnt_next;
  logic                     tx_reg, tx_next;
  logic                     start_stb_reg, start_stb_next;
  logic                     reset_stb_reg, reset_stb_next;
  logic                     done_stb_reg, done_stb_next;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg     <= STATE_IDLE;
      shift_reg     <= '0;
      bit_idx_reg   <= '0;
      stop_cnt_reg  <= 1'b0;
      tx_reg        <= UART_IDLE_LEVEL;
      start_stb_reg <= 1'b0;
      reset_stb_reg <= 1'b0;
      done_stb_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_idx_reg   <= bit_idx_next;
      stop_cnt_reg  <= stop_cnt_next;
      tx_reg        <= tx_next;
      start_stb_reg <= start_stb_next;
      reset_stb_reg <= reset_stb_next;
      done_stb_reg  <= done_stb_next;
    end
  end

  // The line level is computed one cycle ahead so o_tx is a plain flop output.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_idx_next   = bit_idx_reg;
    stop_cnt_next  = stop_cnt_reg;
    tx_next        = tx_reg;
    start_stb_next = 1'b0;
    reset_stb_next = 1'b0;
    done_stb_next  = 1'b0;

    case (state_reg)
      STATE_IDLE: begin
        tx_next = UART_IDLE_LEVEL;
        if (i_data_stb) begin
          shift_next     = i_data;
          tx_next        = UART_START_LEVEL;
          start_stb_next = 1'b1;
          state_next     = STATE_START;
        end
      end

      STATE_START: begin
        if (i_div_clk_rose) begin
          state_next   = STATE_DATA;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end
      end

      STATE_DATA: begin
        if (i_div_clk_rose) begin
          if (bit_idx_reg == BIT_LAST) begin
            state_next    = STATE_STOP;
            stop_cnt_next = 1'b0;
            tx_next       = UART_IDLE_LEVEL;
          end else begin
            shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
            bit_idx_next = bit_idx_reg + BIT_CNT_WIDTH'(1);
            tx_next      = shift_reg[1];
          end
        end
      end

      STATE_STOP: begin
        tx_next = UART_IDLE_LEVEL;
        if (i_div_clk_rose) begin
          if (stop_cnt_reg != STOP_LAST) begin
            stop_cnt_next = 1'b1;
          end else begin
            state_next     = STATE_IDLE;
            reset_stb_next = 1'b1;
            done_stb_next  = 1'b1;
          end
        end
      end

      default: begin
        state_next = STATE_IDLE;
        tx_next    = UART_IDLE_LEVEL;
      end
    endcase
  end

  assign o_tx            = tx_reg;
  assign o_busy          = (state_reg != STATE_IDLE);
  assign o_div_start_stb = start_stb_reg;
  assign o_div_reset_stb = reset_stb_reg;
  assign o_done_stb      = done_stb_reg;

`ifdef FORMAL
  // Strobe width, idle line level and busy/state consistency.
  assert property (@(posedge i_clk) disable iff (!i_reset_n) o_div_start_stb |=> !o_div_start_stb);
  assert property (@(posedge i_clk) disable iff (!i_reset_n) o_div_reset_stb |=> !o_div_reset_stb);
  assert property (@(posedge i_clk) disable iff (!i_reset_n) o_done_stb |=> !o_done_stb);
  assert property (@(posedge i_clk) !(o_div_start_stb && o_div_reset_stb));
  assert property (@(posedge i_clk) (state_reg == STATE_IDLE) |-> o_tx);
  assert property (@(posedge i_clk) o_busy == (state_reg != STATE_IDLE));
`endif

endmodule
